// File: rtl/apb_if.sv
// APB bus bundle between a requester (src) and a completer (sink).
interface apb_if;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    modport src (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport sink (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_req_bridge.sv
// Single-outstanding valid/ready request to APB transfer bridge with an
// access-phase timeout; responses return on a valid/ready channel.
module apb_req_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        rsp_timeout,
    apb_if.src          apbReg
);

    localparam int unsigned     CntW        = $clog2(TIMEOUT_CYCLES);
    localparam logic [CntW-1:0] CntLast     = CntW'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0]     TimeoutData = 32'hBADD_C0DE;

    typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

    state_e          state_q, state_d;
    logic            ready_q, ready_d;
    logic            write_q, write_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            err_q, err_d;
    logic            to_q, to_d;
    logic            sel;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            ready_q <= 1'b0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            to_q    <= to_d;
        end
    end

    always_comb begin
        state_d = state_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        to_d    = to_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid && ready_q) begin
                    write_d = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    cnt_d   = '0;
                    state_d = StSetup;
                end
            end
            StSetup: state_d = StAccess;
            StAccess: begin
                if (apbReg.pready) begin
                    rdata_d = write_q ? 32'h0 : apbReg.prdata;
                    err_d   = apbReg.pslverr;
                    to_d    = 1'b0;
                    state_d = StResp;
                end else if (cnt_q == CntLast) begin
                    rdata_d = TimeoutData;
                    err_d   = 1'b1;
                    to_d    = 1'b1;
                    state_d = StResp;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StResp: begin
                if (rsp_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        // Registered so req_ready stays low while reset is held.
        ready_d = (state_d == StIdle);
    end

    assign sel            = (state_q == StSetup) || (state_q == StAccess);
    assign apbReg.psel    = sel;
    assign apbReg.penable = (state_q == StAccess);
    assign apbReg.pwrite  = sel & write_q;
    assign apbReg.paddr   = addr_q;
    assign apbReg.pwdata  = wdata_q;

    assign req_ready   = ready_q;
    assign rsp_valid   = (state_q == StResp);
    assign rsp_rdata   = rdata_q;
    assign rsp_err     = err_q;
    assign rsp_timeout = to_q;

endmodule

// File: tb/tb_apb_req_bridge.sv
// Self-checking bench for apb_req_bridge: directed vector table, reset corner case,
// and randomized transfers against a transaction-level reference model.
module tb_apb_req_bridge;
    localparam int unsigned T = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;

    apb_if apb();

    apb_req_bridge #(.TIMEOUT_CYCLES(T)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .rsp_timeout(rsp_timeout),
        .apbReg     (apb)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          waits;   // -1: slave never answers
        logic [31:0] prdata;
        logic        slverr;
        int          hold;
        int          e_acc;
        int          e_lat;
        logic [31:0] e_rdata;
        logic        e_err;
        logic        e_to;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chkb(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Transaction-level expectation: pready on wait index N wins if N < T, else abort.
    function automatic void model(input logic wr, input int waits, input logic [31:0] prdata,
                                  input logic slverr, output int acc, output int lat,
                                  output logic [31:0] rd, output logic err, output logic to);
        if (waits >= 0 && waits < int'(T)) begin
            acc = waits + 1;
            lat = waits + 3;
            rd  = wr ? 32'h0 : prdata;
            err = slverr;
            to  = 1'b0;
        end else begin
            acc = int'(T);
            lat = int'(T) + 2;
            rd  = 32'hBADD_C0DE;
            err = 1'b1;
            to  = 1'b1;
        end
    endfunction

    task automatic run_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                            input int waits, input logic [31:0] rdata, input logic slverr,
                            input int hold, output int acc, output int lat,
                            output logic [31:0] r_rdata, output logic r_err, output logic r_to);
        chkb("idle req_ready", req_ready, 1'b1);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        apb.pready = 1'b0;
        step();
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_wdata = $urandom;
        lat = 1;
        chkb("setup psel", apb.psel, 1'b1);
        chkb("setup penable", apb.penable, 1'b0);
        chkb("setup pwrite", apb.pwrite, wr);
        chk("setup paddr", apb.paddr, addr);
        if (wr) chk("setup pwdata", apb.pwdata, wdata);
        chkb("setup req_ready", req_ready, 1'b0);
        step();
        lat = 2;
        acc = 0;
        while (rsp_valid !== 1'b1) begin
            if (lat >= 40) begin
                chkb("response within bound", 1'b0, 1'b1);
                rst = 1'b1;
                #1 rst = 1'b0;
                step();
                break;
            end
            chkb("access psel", apb.psel, 1'b1);
            chkb("access penable", apb.penable, 1'b1);
            chk("access paddr", apb.paddr, addr);
            chkb("access pwrite", apb.pwrite, wr);
            acc++;
            if (waits >= 0 && acc - 1 == waits) begin
                apb.pready  = 1'b1;
                apb.prdata  = rdata;
                apb.pslverr = slverr;
            end else begin
                apb.pready  = 1'b0;
                apb.prdata  = $urandom;
                apb.pslverr = 1'($urandom);
            end
            step();
            lat++;
        end
        apb.pready = 1'b0;
        chkb("resp psel", apb.psel, 1'b0);
        chkb("resp penable", apb.penable, 1'b0);
        chkb("resp pwrite", apb.pwrite, 1'b0);
        chkb("resp req_ready", req_ready, 1'b0);
        r_rdata = rsp_rdata;
        r_err   = rsp_err;
        r_to    = rsp_timeout;
        // Stall the response while disturbing every input that must be ignored.
        for (int i = 0; i < hold; i++) begin
            rsp_ready   = 1'b0;
            req_valid   = 1'b1;
            req_write   = 1'($urandom);
            req_addr    = $urandom;
            apb.pready  = 1'($urandom);
            apb.prdata  = $urandom;
            apb.pslverr = 1'($urandom);
            step();
            chkb("hold rsp_valid", rsp_valid, 1'b1);
            chk("hold rsp_rdata", rsp_rdata, r_rdata);
            chkb("hold rsp_err", rsp_err, r_err);
            chkb("hold rsp_timeout", rsp_timeout, r_to);
            chkb("hold req_ready", req_ready, 1'b0);
            chkb("hold psel", apb.psel, 1'b0);
        end
        apb.pready = 1'b0;
        rsp_ready  = 1'b1;
        step();
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        chkb("post rsp_valid", rsp_valid, 1'b0);
        chkb("post req_ready", req_ready, 1'b1);
        chkb("post psel", apb.psel, 1'b0);
        chkb("post pwrite", apb.pwrite, 1'b0);
        chk("post paddr kept", apb.paddr, addr);
    endtask

    task automatic check_vec(input vec_t v, input string tag);
        int acc, lat;
        logic [31:0] rd;
        logic err, to;
        run_xfer(v.wr, v.addr, v.wdata, v.waits, v.prdata, v.slverr, v.hold,
                 acc, lat, rd, err, to);
        chk({tag, " access cycles"}, acc, v.e_acc);
        chk({tag, " latency"}, lat, v.e_lat);
        chk({tag, " rsp_rdata"}, rd, v.e_rdata);
        chkb({tag, " rsp_err"}, err, v.e_err);
        chkb({tag, " rsp_timeout"}, to, v.e_to);
    endtask

    initial begin
        vec_t vecs[8];
        vec_t v;
        vecs[0] = '{1'b1, 32'hA8, 32'h7F, 0, 32'h0, 1'b0, 0, 1, 3, 32'h0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 32'h04, 32'h0, 3, 32'h1234_5678, 1'b0, 0, 4, 6, 32'h1234_5678,
                    1'b0, 1'b0};
        vecs[2] = '{1'b0, 32'hFC, 32'h0, 0, 32'hBADD_C0DE, 1'b1, 0, 1, 3, 32'hBADD_C0DE,
                    1'b1, 1'b0};
        vecs[3] = '{1'b0, 32'h10, 32'h0, -1, 32'h55AA_55AA, 1'b0, 2, 8, 10, 32'hBADD_C0DE,
                    1'b1, 1'b1};
        vecs[4] = '{1'b1, 32'h20, 32'hDEAD_BEEF, 7, 32'hFFFF_FFFF, 1'b0, 0, 8, 10, 32'h0,
                    1'b0, 1'b0};
        vecs[5] = '{1'b1, 32'h24, 32'h1, 8, 32'h0, 1'b0, 0, 8, 10, 32'hBADD_C0DE,
                    1'b1, 1'b1};
        vecs[6] = '{1'b0, 32'h08, 32'h0, 1, 32'hCAFE_F00D, 1'b0, 5, 2, 4, 32'hCAFE_F00D,
                    1'b0, 1'b0};
        vecs[7] = '{1'b1, 32'h30, 32'h5, 2, 32'h1212_1212, 1'b1, 0, 3, 5, 32'h0,
                    1'b1, 1'b0};

        apb.pready  = 1'b0;
        apb.prdata  = '0;
        apb.pslverr = 1'b0;

        #2;
        chkb("reset req_ready", req_ready, 1'b0);
        chkb("reset rsp_valid", rsp_valid, 1'b0);
        chkb("reset psel", apb.psel, 1'b0);
        chkb("reset penable", apb.penable, 1'b0);
        chkb("reset pwrite", apb.pwrite, 1'b0);
        chk("reset paddr", apb.paddr, 32'h0);
        chk("reset pwdata", apb.pwdata, 32'h0);
        chk("reset rsp_rdata", rsp_rdata, 32'h0);
        chkb("reset rsp_err", rsp_err, 1'b0);
        chkb("reset rsp_timeout", rsp_timeout, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chkb("release req_ready before edge", req_ready, 1'b0);
        step();
        chkb("first edge req_ready", req_ready, 1'b1);

        for (int i = 0; i < 8; i++) check_vec(vecs[i], $sformatf("vec%0d", i));

        // Reset during the ACCESS phase of a read.
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 32'h40;
        step();
        req_valid = 1'b0;
        step();
        chkb("pre-reset penable", apb.penable, 1'b1);
        #2 rst = 1'b1;
        #1;
        chkb("async reset psel", apb.psel, 1'b0);
        chkb("async reset penable", apb.penable, 1'b0);
        chkb("async reset rsp_valid", rsp_valid, 1'b0);
        chkb("async reset req_ready", req_ready, 1'b0);
        apb.pready = 1'b1;
        step();
        chkb("in reset rsp_valid", rsp_valid, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        apb.pready = 1'b0;
        step();
        chkb("after reset req_ready", req_ready, 1'b1);
        chkb("after reset rsp_valid", rsp_valid, 1'b0);
        chkb("after reset psel", apb.psel, 1'b0);
        v = '{1'b1, 32'h44, 32'hA5A5_0001, 1, 32'h9999_9999, 1'b0, 1, 2, 4, 32'h0,
              1'b0, 1'b0};
        check_vec(v, "post-reset write");

        // Randomized transfers against the reference model.
        for (int i = 0; i < 40; i++) begin
            v.wr     = 1'($urandom);
            v.addr   = $urandom & 32'hFFFF_FFFC;
            v.wdata  = $urandom;
            v.waits  = int'($urandom_range(0, 11)) - 1;
            v.prdata = $urandom;
            v.slverr = 1'($urandom);
            v.hold   = int'($urandom_range(0, 3));
            model(v.wr, v.waits, v.prdata, v.slverr, v.e_acc, v.e_lat, v.e_rdata,
                  v.e_err, v.e_to);
            check_vec(v, $sformatf("rand%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
